alu_result_tx: RTL and testbench
================================

# alu_result_tx

Serial result transmitter for the ALU board design. It captures a registered ALU result on a one-cycle valid strobe and shifts it out on a single UART-style line: start bit, 8 data bits LSB first, optional even parity, and one stop bit. It sits after the ALU result register, in the output direction of the switch/button operand-loading path, so results can be read by a host as well as on the LEDs.

## Interface

Parameters:
- NB_DATA, 4: ALU result width. Legal range 1..8. Zero-extended to 8 bits in the frame.
- CLK_PER_BIT, 16: clock cycles per serial bit. Minimum 2.
- PARITY_EN, 0: 1 inserts an even-parity bit over the 8 frame data bits, between the data bits and the stop bit.

Ports:
- clock, input, 1: single system clock; all logic is on the rising edge.
- i_reset, input, 1: asynchronous, active-low reset. Asserts immediately; deassertion is synchronised to clock.
- i_data, input, NB_DATA: ALU result to send. Sampled only on an accepted i_valid.
- i_valid, input, 1: send request. Accepted when high on a rising edge while o_busy=0.
- o_tx, output, 1: serial line. Idle level is high.
- o_busy, output, 1: high from the cycle after acceptance through the last stop-bit cycle.
- o_done, output, 1: one-cycle pulse when a frame completes.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1 and o_busy=0.
  - If i_valid=1 on an edge, the block latches {zero-extend(i_data)} into an 8-bit shift register, computes parity as the XOR of those 8 bits, clears the bit-timer and bit index, and moves to START.
- START: o_tx=0 for CLK_PER_BIT cycles, then DATA.
- DATA: o_tx=shift[0] for each bit.
  - The register shifts right every CLK_PER_BIT cycles.
  - The bit index runs 0..7. After bit 7 the block moves to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: o_tx=parity for CLK_PER_BIT cycles, then STOP.
- STOP: o_tx=1 for CLK_PER_BIT cycles, then IDLE with o_done=1 for exactly that one cycle.
- Bit timer: counts 0..CLK_PER_BIT-1 and wraps to 0 at each bit boundary. Its width is clog2(CLK_PER_BIT).
- If i_valid is high while o_busy=1, it is ignored. There is no queuing and no error flag.
- i_data changing while o_busy=1 has no effect on the frame in flight.
- Reset asserted mid-frame:
  - o_tx=1, o_busy=0 and o_done=0 immediately, asynchronously.
  - The state returns to IDLE and the frame is aborted.
  - No o_done is produced for the aborted frame.

## Timing

- Reset values: o_tx=1, o_busy=0, o_done=0, state IDLE, shift register 0, timer 0, bit index 0.
- Acceptance edge is cycle 0. The frame occupies cycles 1..F, where F=(10+PARITY_EN)*CLK_PER_BIT.
  - Start bit: cycles 1..CLK_PER_BIT.
  - Data bit k: cycles (1+k)*CLK_PER_BIT+1 .. (2+k)*CLK_PER_BIT.
  - Stop bit: the last CLK_PER_BIT cycles of the frame.
- o_busy=1 in cycles 1..F and 0 in cycle F+1.
- o_done=1 in cycle F+1 only.
- Back-to-back frames: i_valid high in cycle F+1 (while o_done=1) is accepted. The next start bit begins in cycle F+2, with no extra idle gap beyond that cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- Reset check: hold i_reset=0 for 5 cycles with i_valid=1. Required: o_tx=1, o_busy=0, o_done=0 throughout.
- Basic frame: CLK_PER_BIT=4, PARITY_EN=0, i_data=4'b1010, one-cycle i_valid.
  - Required o_tx per 4-cycle bit: 0,0,1,0,1,0,0,0,0,1.
  - Required: o_busy high for cycles 1..40 and o_done pulse in cycle 41.
- Parity frame: CLK_PER_BIT=4, PARITY_EN=1, i_data=4'b0111.
  - Required bits: 0,1,1,1,0,0,0,0,0, then parity 1, then stop 1.
  - Required: o_done in cycle 45.
- Busy ignore: start a frame with 4'b0001, then pulse i_valid with 4'b1111 in cycle 10.
  - Required: only the 0x01 frame is sent and one o_done pulse occurs.
  - Required: o_tx stays high after the stop bit.
- Back-to-back: send 4'b0011, then assert i_valid with 4'b1100 in the o_done cycle.
  - Required: the second start bit begins the next cycle.
  - Required: the second frame's data bits are 0,0,1,1,0,0,0,0.
- Mid-frame reset: assert i_reset=0 during data bit 3.
  - Required: o_tx=1 and o_busy=0 within the same cycle, with no o_done.
  - After release, a new frame of 4'b0101 must transmit correctly.

Source files
------------

// File: rtl/alu_result_tx_if.sv
// alu_result_tx_if: send-request and serial-line bundle for alu_result_tx.
`default_nettype none

interface alu_result_tx_if #(
  parameter int NB_DATA = 4
);
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_tx;
  logic               o_busy;
  logic               o_done;

  modport master (output i_data, output i_valid, input o_tx, input o_busy, input o_done);
  modport slave  (input i_data, input i_valid, output o_tx, output o_busy, output o_done);
endinterface

`default_nettype wire

// File: rtl/alu_result_tx.sv
// alu_result_tx: shifts a captured ALU result out as start, 8 data LSB-first,
// optional even parity and stop bit on a single idle-high line.
`default_nettype none

module alu_result_tx #(
  parameter int NB_DATA     = 4,
  parameter int CLK_PER_BIT = 16,
  parameter int PARITY_EN   = 0
) (
  input  logic                 clock,
  input  logic                 i_reset,
  alu_result_tx_if.slave       bus
);

  localparam int            TW   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLK_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_idx;
  logic          r_done;
  logic          w_bit_end;
  logic [7:0]    w_data_ext;

  // Reset asserts asynchronously but releases two edges later, in step with clock.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_bit_end = (r_timer == TMAX);

  always_comb begin
    w_data_ext              = 8'd0;
    w_data_ext[NB_DATA-1:0] = bus.i_data;
  end

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.i_valid) w_state_next = S_START;
      S_START:  if (w_bit_end) w_state_next = S_DATA;
      S_DATA:   if (w_bit_end && (r_idx == 3'd7))
                  w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
      S_STOP:   if (w_bit_end) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_shift  <= 8'd0;
      r_parity <= 1'b0;
      r_timer  <= '0;
      r_idx    <= 3'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_STOP) && w_bit_end;
      if (r_state == S_IDLE) begin
        r_timer <= '0;
        r_idx   <= 3'd0;
        if (bus.i_valid) begin
          r_shift  <= w_data_ext;
          r_parity <= ^w_data_ext;
        end
      end else begin
        r_timer <= w_bit_end ? '0 : r_timer + TW'(1);
        if ((r_state == S_DATA) && w_bit_end) begin
          r_shift <= {1'b0, r_shift[7:1]};
          r_idx   <= r_idx + 3'd1;
        end
      end
    end
  end

  // Outputs depend only on flops, so reset forces the idle line level at once.
  always_comb begin
    bus.o_tx = 1'b1;
    case (r_state)
      S_START:  bus.o_tx = 1'b0;
      S_DATA:   bus.o_tx = r_shift[0];
      S_PARITY: bus.o_tx = r_parity;
      default:  bus.o_tx = 1'b1;
    endcase
    bus.o_busy = (r_state != S_IDLE);
    bus.o_done = r_done;
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_tx.sv
// tb_alu_result_tx: directed frames on a no-parity and a parity instance.
`default_nettype none

module tb_alu_result_tx;
  localparam int CPB = 4;

  logic clock = 1'b0;
  logic i_reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  alu_result_tx_if #(.NB_DATA(4)) if0 ();
  alu_result_tx_if #(.NB_DATA(4)) if1 ();

  alu_result_tx #(.NB_DATA(4), .CLK_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (if0.slave)
  );

  alu_result_tx #(.NB_DATA(4), .CLK_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (if1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [3:0] d);
    if (sel == 0) begin
      if0.i_valid = v;
      if0.i_data  = d;
    end else begin
      if1.i_valid = v;
      if1.i_data  = d;
    end
  endtask

  function automatic logic [2:0] outs(input int sel);
    return (sel == 0) ? {if0.o_tx, if0.o_busy, if0.o_done}
                      : {if1.o_tx, if1.o_busy, if1.o_done};
  endfunction

  task automatic check_idle(input string tag, input int sel);
    logic [2:0] o;
    o = outs(sel);
    chk({tag, "_tx"},   o[2], 1'b1);
    chk({tag, "_busy"}, o[1], 1'b0);
    chk({tag, "_done"}, o[0], 1'b0);
  endtask

  // Leaves the bench at the falling edge of frame cycle 1.
  task automatic send(input int sel, input logic [3:0] d);
    @(negedge clock);
    drive(sel, 1'b1, d);
    @(negedge clock);
    drive(sel, 1'b0, d);
  endtask

  // bits[i] is the i-th transmitted bit; checks cycles 1..F+1, optional request injected at cycle inj.
  task automatic check_frame(input string tag, input int sel, input logic [10:0] bits,
                             input int nbits, input int inj, input logic [3:0] inj_d);
    int         f;
    logic [2:0] o;
    f = nbits * CPB;
    for (int n = 1; n <= f + 1; n++) begin
      o = outs(sel);
      if (n <= f) begin
        chk($sformatf("%s_c%0d_tx", tag, n),   o[2], bits[(n-1)/CPB]);
        chk($sformatf("%s_c%0d_busy", tag, n), o[1], 1'b1);
        chk($sformatf("%s_c%0d_done", tag, n), o[0], 1'b0);
      end else begin
        chk($sformatf("%s_c%0d_tx", tag, n),   o[2], 1'b1);
        chk($sformatf("%s_c%0d_busy", tag, n), o[1], 1'b0);
        chk($sformatf("%s_c%0d_done", tag, n), o[0], 1'b1);
      end
      if (n == inj + 1) drive(sel, 1'b0, inj_d);
      if (n == inj)     drive(sel, 1'b1, inj_d);
      if (n <= f) @(negedge clock);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    drive(0, 1'b0, 4'h0);
    drive(1, 1'b0, 4'h0);
    #1 i_reset = 1'b0;

    drive(0, 1'b1, 4'hF);
    drive(1, 1'b1, 4'hF);
    repeat (5) begin
      @(negedge clock);
      check_idle("rst0", 0);
      check_idle("rst1", 1);
    end
    drive(0, 1'b0, 4'h0);
    drive(1, 1'b0, 4'h0);
    @(negedge clock);
    i_reset = 1'b1;
    repeat (3) @(negedge clock);
    check_idle("post_rst", 0);

    send(0, 4'b1010);
    check_frame("basic", 0, 11'b01000010100, 10, 0, 4'h0);
    repeat (2) @(negedge clock);
    check_idle("basic_after", 0);

    send(1, 4'b0111);
    check_frame("par", 1, 11'b11000001110, 11, 0, 4'h0);
    @(negedge clock);
    check_idle("par_after", 1);

    send(0, 4'b0001);
    check_frame("busy", 0, 11'b01000000010, 10, 10, 4'b1111);
    repeat (8) begin
      @(negedge clock);
      check_idle("busy_after", 0);
    end

    send(0, 4'b0011);
    check_frame("b2b_a", 0, 11'b01000000110, 10, 41, 4'b1100);
    @(negedge clock);
    drive(0, 1'b0, 4'b1100);
    check_frame("b2b_b", 0, 11'b01000011000, 10, 0, 4'h0);

    send(0, 4'b0111);
    repeat (17) @(negedge clock);
    chk("mid_pre_tx",   if0.o_tx, 1'b0);
    chk("mid_pre_busy", if0.o_busy, 1'b1);
    #1 i_reset = 1'b0;
    #1 check_idle("mid_rst", 0);
    @(negedge clock);
    check_idle("mid_hold", 0);
    i_reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check_idle("mid_release", 0);
    end
    send(0, 4'b0101);
    check_frame("after_rst", 0, 11'b01000001010, 10, 0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
